// File: rtl/div255_pkg.sv
// -----------------------------------------------------------------------------
// div255_pkg
//   Shared definitions for the divide-by-255 host controller:
//   - state_t        : controller FSM states
//   - HOLD_CYC_DEF   : default cycles each load/read phase is held on the bus
//   - WAIT_CYC_DEF   : default idle cycles between load and read
//   - DIVISOR        : the fixed divisor implemented by the external divider
// -----------------------------------------------------------------------------
package div255_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_HI,
        LD_LO,
        COMPUTE,
        RD_HI,
        RD_LO,
        DONE
    } state_t;

    localparam int unsigned HOLD_CYC_DEF = 10;
    localparam int unsigned WAIT_CYC_DEF = 10;
    localparam int unsigned DIVISOR      = 255;

endpackage

// File: rtl/div255_phase_timer.sv
// -----------------------------------------------------------------------------
// div255_phase_timer
//   8-bit down-counter that times one FSM phase. Loading a value N makes
//   done assert on the N-th cycle after the load edge, i.e. on the last cycle
//   of an N-cycle phase. The counter parks at zero when not reloaded.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count cleared)
//   load  : reload the counter with value on this edge
//   value : phase length in cycles (1..255)
//   done  : high on the final cycle of the current phase
// -----------------------------------------------------------------------------
module div255_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd1);

endmodule

// File: rtl/div255_host.sv
// -----------------------------------------------------------------------------
// div255_host
//   Host-side sequencer for an external divide-by-255 unit. Accepts a 32-bit
//   dividend, presents it to the divider as two 16-bit halves (flg1/flg2
//   strobes), waits for the divider to settle, reads back the quotient halves
//   (flg3/flg4 strobes) and offers the 32-bit quotient on a valid/ready port.
// Parameters:
//   HOLD_CYC : cycles each load/read phase is held on the bus (1..255)
//   WAIT_CYC : idle cycles between load and read (0..255, 0 skips COMPUTE)
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, in_data = dividend
//   x                   : data bus to divider
//   flg1..flg4          : load-MSB, load-LSB, read-MSB, read-LSB strobes
//   y                   : quotient half returned by the divider
//   out_valid/out_ready : result handshake
//   quot                : quotient {MSB half, LSB half}
//   rem                 : remainder
// Configuration:
//   DIVISOR-remainder output is built only when DIV255_HOST_REM_EN is
//   defined; otherwise rem is tied to zero.
// -----------------------------------------------------------------------------
module div255_host
    import div255_pkg::*;
#(
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [15:0] x,
    output logic        flg1,
    output logic        flg2,
    output logic        flg3,
    output logic        flg4,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quot,
    output logic [7:0]  rem
);

    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYC);

    state_t      state;
    logic [31:0] opnd;
    logic        t_load;
    logic [7:0]  t_value;
    logic        t_done;
    logic        accept;

    assign accept = in_valid && in_ready;

    div255_phase_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (t_load),
        .value (t_value),
        .done  (t_done)
    );

    // Timer reload on every state entry, with the length of the state entered.
    always_comb begin
        t_load  = 1'b0;
        t_value = HOLD_LD;
        case (state)
            IDLE:    t_load = accept;
            LD_HI:   t_load = t_done;
            LD_LO: begin
                t_load = t_done;
                if (WAIT_CYC != 0) t_value = WAIT_LD;
            end
            COMPUTE: t_load = t_done;
            RD_HI:   t_load = t_done;
            default: t_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            opnd      <= '0;
            x         <= '0;
            flg1      <= 1'b0;
            flg2      <= 1'b0;
            flg3      <= 1'b0;
            flg4      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quot      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        opnd     <= in_data;
                        x        <= in_data[31:16];
                        flg1     <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (t_done) begin
                        x     <= opnd[15:0];
                        flg1  <= 1'b0;
                        flg2  <= 1'b1;
                        state <= LD_LO;
                    end
                end
                LD_LO: begin
                    if (t_done) begin
                        flg2 <= 1'b0;
                        if (WAIT_CYC == 0) begin
                            flg3  <= 1'b1;
                            state <= RD_HI;
                        end else begin
                            state <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (t_done) begin
                        flg3  <= 1'b1;
                        state <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (t_done) begin
                        quot[31:16] <= y;
                        flg3        <= 1'b0;
                        flg4        <= 1'b1;
                        state       <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (t_done) begin
                        quot[15:0] <= y;
                        flg4       <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV255_HOST_REM_EN
    logic [7:0] rem_q;
    logic [7:0] rem_nxt;

    // Low byte of (q<<8)-q depends only on q[7:0] and equals -q[7:0];
    // q[7:0] is y[7:0] on the RD_LO capture cycle.
    always_comb begin
        rem_nxt = opnd[7:0] - (8'h00 - y[7:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
        end else if (state == RD_LO && t_done) begin
            rem_q <= rem_nxt;
        end
    end

    assign rem = rem_q;
`else
    assign rem = '0;
`endif

endmodule

// File: tb/tb_div255_host.sv
// -----------------------------------------------------------------------------
// tb_div255_host
//   Directed bench for div255_host with default parameters, paired with a
//   behavioural divide-by-255 unit driven by the host's bus and strobes.
// -----------------------------------------------------------------------------
module tb_div255_host;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [15:0] x;
    logic        flg1, flg2, flg3, flg4;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quot;
    logic [7:0]  rem;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int unsigned onehot_viol = 0;

`ifdef DIV255_HOST_REM_EN
    localparam logic [7:0] REM_256 = 8'd1;
`else
    localparam logic [7:0] REM_256 = 8'd0;
`endif

    div255_host dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .x         (x),
        .flg1      (flg1),
        .flg2      (flg2),
        .flg3      (flg3),
        .flg4      (flg4),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural divider: latches halves on load strobes, returns quotient
    // halves while a read strobe is high.
    logic [15:0] m_hi = '0;
    logic [15:0] m_lo = '0;
    logic [31:0] m_q;

    always @(posedge clk) begin
        if (flg1) m_hi <= x;
        if (flg2) m_lo <= x;
    end

    assign m_q = {m_hi, m_lo} / 32'd255;
    assign y   = flg3 ? m_q[31:16] : (flg4 ? m_q[15:0] : 16'h0000);

    always @(negedge clk) begin
        if (!rst && (int'(flg1) + int'(flg2) + int'(flg3) + int'(flg4)) > 1)
            onehot_viol <= onehot_viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first LD_HI cycle.
    task automatic send(input string tag, input logic [31:0] op);
        int unsigned n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = op;
        acc_cyc  = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ldhi_flg1"}, 32'(flg1), 32'd1);
        check({tag, "_ldhi_x"}, 32'(x), {16'h0000, op[31:16]});
    endtask

    task automatic wait_result(input string tag, input logic [31:0] eq, input logic [7:0] er);
        int unsigned n = 0;
        while (!out_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, cyc - acc_cyc, 32'd51);
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, 32'(rem), 32'(er));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] op,
                          input logic [31:0] eq, input logic [7:0] er);
        send(tag, op);
        wait_result(tag, eq, er);
        consume(tag);
    endtask

    initial begin
        int unsigned n;
        logic        ov_seen;

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        check("rst_x", 32'(x), 32'd0);
        check("rst_flags", 32'({flg1, flg2, flg3, flg4}), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("op25500", 32'd25500, 32'h0000_0064, 8'd0);
        run_op("op255000", 32'd255000, 32'd1000, 8'd0);
        run_op("op256", 32'd256, 32'd1, REM_256);
        run_op("op0", 32'd0, 32'd0, 8'd0);
        run_op("opmax", 32'hFFFF_FFFF, 32'h0101_0101, 8'd0);

        // Reset in the middle of RD_HI
        send("mid", 32'd1000);
        n = 0;
        while (!flg3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_rdhi_reached", 32'(flg3), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_flags", 32'({flg1, flg2, flg3, flg4}), 32'd0);
        check("mid_ov", 32'(out_valid), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        check("mid_x", 32'(x), 32'd0);
        check("mid_quot", quot, 32'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        check("mid_no_ov", 32'(ov_seen), 32'd0);
        run_op("after_rst", 32'd255, 32'd1, 8'd0);

        // Result held in DONE with a competing operand offered
        send("hold", 32'd510);
        wait_result("hold", 32'd2, 8'd0);
        in_valid = 1'b1;
        in_data  = 32'd25500;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_quot", quot, 32'd2);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_ov", 32'(out_valid), 32'd1);
        end
        check("hold_rem", 32'(rem), 32'd0);
        out_ready = 1'b1;
        acc_cyc   = cyc + 1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_consume_ov", 32'(out_valid), 32'd0);
        check("hold_consume_ready", 32'(in_ready), 32'd1);
        check("hold_no_same_cycle_accept", 32'(flg1), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold_accepted_ready", 32'(in_ready), 32'd0);
        check("hold_accepted_flg1", 32'(flg1), 32'd1);
        wait_result("after_hold", 32'd100, 8'd0);
        consume("after_hold");

        check("flag_onehot", onehot_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
